// File: rtl/counter_pkg.sv
// Shared definitions for the counter command sequencer: mode encodings,
// sequencer states and the default counter width.
package counter_pkg;

  localparam int DEFAULT_WIDTH = 5;

  typedef enum logic [1:0] {
    MODE_LOAD      = 2'b00,
    MODE_SEEK      = 2'b01,
    MODE_RAMP_UP   = 2'b10,
    MODE_RAMP_DOWN = 2'b11
  } mode_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SEEK,
    ST_RAMP,
    ST_RESP
  } state_t;

endpackage

// File: rtl/counter_driver_if.sv
// Bundle of the command request/response port and the up/down counter port.
// The master side is the sequencer; the slave side is the requester plus counter.
interface counter_driver_if #(
  parameter int WIDTH = counter_pkg::DEFAULT_WIDTH
);

  logic             Req_Valid;
  logic             Req_Ready;
  logic [1:0]       Req_Mode;
  logic [WIDTH-1:0] Req_Value;
  logic             Rsp_Valid;
  logic             Rsp_Err;
  logic [WIDTH-1:0] In;
  logic             Load;
  logic             Up;
  logic             Down;
  logic [WIDTH-1:0] Counter;
  logic             High;
  logic             Low;

  modport master (
    input  Req_Valid, Req_Mode, Req_Value, Counter, High, Low,
    output Req_Ready, Rsp_Valid, Rsp_Err, In, Load, Up, Down
  );

  modport slave (
    output Req_Valid, Req_Mode, Req_Value, Counter, High, Low,
    input  Req_Ready, Rsp_Valid, Rsp_Err, In, Load, Up, Down
  );

endinterface

// File: rtl/counter_driver.sv
// Command sequencer for the up/down counter: loads, seeks or ramps the counter
// one step per cycle and reports completion or a step-budget timeout.
module counter_driver
  import counter_pkg::*;
#(
  parameter int WIDTH   = DEFAULT_WIDTH,
  parameter int TIMEOUT = 40
) (
  input logic              Clk,
  input logic              Rst,
  counter_driver_if.master bus
);

  localparam int TW = $clog2(TIMEOUT + 1);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] target_q;
  logic             dir_up_q;
  logic             err_q;
  logic [TW-1:0]    tcount_q;

  logic req_ready, load, up, down, rsp_valid, rsp_err;
  logic set_err, timeout_hit, ramp_done;

  assign timeout_hit = (tcount_q == TW'(TIMEOUT));
  assign ramp_done   = dir_up_q ? bus.High : bus.Low;

  // Goal checks take priority over the budget so a step landing on the
  // target at the last allowed cycle still completes cleanly.
  always_comb begin
    state_d   = state_q;
    req_ready = 1'b0;
    load      = 1'b0;
    up        = 1'b0;
    down      = 1'b0;
    rsp_valid = 1'b0;
    rsp_err   = 1'b0;
    set_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (bus.Req_Valid) begin
          case (mode_t'(bus.Req_Mode))
            MODE_LOAD: state_d = ST_LOAD;
            MODE_SEEK: state_d = ST_SEEK;
            default:   state_d = ST_RAMP;
          endcase
        end
      end
      ST_LOAD: begin
        load    = 1'b1;
        state_d = ST_RESP;
      end
      ST_SEEK: begin
        if (bus.Counter == target_q) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          set_err = 1'b1;
        end else if (bus.Counter < target_q) begin
          up = 1'b1;
        end else begin
          down = 1'b1;
        end
      end
      ST_RAMP: begin
        if (ramp_done) begin
          state_d = ST_RESP;
        end else if (timeout_hit) begin
          state_d = ST_RESP;
          set_err = 1'b1;
        end else begin
          up   = dir_up_q;
          down = !dir_up_q;
        end
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        rsp_err   = err_q;
        state_d   = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q  <= ST_IDLE;
      target_q <= '0;
      dir_up_q <= 1'b0;
      err_q    <= 1'b0;
      tcount_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_IDLE && bus.Req_Valid) begin
        target_q <= bus.Req_Value;
        dir_up_q <= (mode_t'(bus.Req_Mode) == MODE_RAMP_UP);
        err_q    <= 1'b0;
        tcount_q <= '0;
      end else begin
        if (up || down) tcount_q <= tcount_q + 1'b1;
        if (set_err)    err_q    <= 1'b1;
      end
    end
  end

  assign bus.Req_Ready = req_ready;
  assign bus.Rsp_Valid = rsp_valid;
  assign bus.Rsp_Err   = rsp_err;
  assign bus.In        = target_q;
  assign bus.Load      = load;
  assign bus.Up        = up;
  assign bus.Down      = down;

endmodule

// File: tb/tb_counter_driver.sv
// Bench for counter_driver: a behavioural up/down counter sits on the counter
// port, and command outcomes are predicted from distances and step counts.
module tb_counter_driver;

  localparam int W       = 5;
  localparam int TIMEOUT = 40;
  localparam int TOP     = (1 << W) - 1;

  logic         Clk = 1'b0;
  logic         Rst = 1'b0;
  logic [W-1:0] cnt;
  bit           stuck = 1'b0;
  int           errors = 0;
  int           checks = 0;
  int           model_cnt = 0;

  counter_driver_if #(.WIDTH(W)) bus();

  counter_driver #(.WIDTH(W), .TIMEOUT(TIMEOUT)) dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus.master)
  );

  always #5 Clk = ~Clk;

  // Counter under control; 'stuck' freezes it to emulate a broken counter.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst)           cnt <= '0;
    else if (!stuck) begin
      if (bus.Load)      cnt <= bus.In;
      else if (bus.Up)   cnt <= cnt + 1'b1;
      else if (bus.Down) cnt <= cnt - 1'b1;
    end
  end

  assign bus.Counter = cnt;
  assign bus.High    = (cnt == W'(TOP));
  assign bus.Low     = (cnt == '0);

  // Expected outcome of one command from the current count.
  function automatic void model_cmd(input int c, input int mode, input int v,
                                    output int lat, output bit err, output int ups,
                                    output int downs, output int loads, output int nc);
    ups = 0; downs = 0; loads = 0; err = 1'b0; nc = c;
    case (mode)
      0: begin loads = 1; nc = v; end
      1: begin if (v > c) ups = v - c; else downs = c - v; nc = v; end
      2: begin ups = TOP - c; nc = TOP; end
      default: begin downs = c; nc = 0; end
    endcase
    lat = (loads != 0) ? 2 : ups + downs + 2;
  endfunction

  // Issue one command from idle and watch it until the response pulse.
  task automatic applyStimulus(input logic [1:0] mode, input logic [W-1:0] value,
                               input int limit, output int rsp_at, output bit err,
                               output int ups, output int downs, output int loads,
                               output int bad, output logic [W-1:0] load_val);
    rsp_at = -1; err = 1'b0; ups = 0; downs = 0; loads = 0; bad = 0; load_val = '0;
    bus.Req_Valid = 1'b1;
    bus.Req_Mode  = mode;
    bus.Req_Value = value;
    @(posedge Clk); #1;
    bus.Req_Valid = 1'b0;
    for (int k = 1; k <= limit; k++) begin
      if (bus.Up)   ups++;
      if (bus.Down) downs++;
      if (bus.Load) begin loads++; load_val = bus.In; end
      if ((bus.Up && bus.High) || (bus.Down && bus.Low) ||
          (int'(bus.Up) + int'(bus.Down) + int'(bus.Load) > 1) || bus.Req_Ready)
        bad++;
      if (bus.Rsp_Valid) begin
        rsp_at = k;
        err    = bus.Rsp_Err;
        @(posedge Clk); #1;
        break;
      end
      @(posedge Clk); #1;
    end
  endtask

  task automatic test_reset;
    bus.Req_Valid = 1'b0; bus.Req_Mode = 2'b00; bus.Req_Value = '0;
    Rst = 1'b0;
    repeat (3) @(posedge Clk);
    #1;
    checks++;
    if ({bus.Load, bus.Up, bus.Down, bus.Rsp_Valid, bus.Rsp_Err} !== 5'b0) begin
      errors++;
      $display("[TB] FAIL reset_controls: got %b want 00000",
               {bus.Load, bus.Up, bus.Down, bus.Rsp_Valid, bus.Rsp_Err});
    end
    checks++;
    if (bus.In !== '0) begin
      errors++; $display("[TB] FAIL reset_in: got %0d want 0", bus.In);
    end
    Rst = 1'b1;
    #1;
    checks++;
    if (bus.Req_Ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_ready: got %b want 1", bus.Req_Ready);
    end
    @(posedge Clk); #1;
    model_cnt = 0;
  endtask

  task automatic test_reset_mid_seek;
    int rsp_at, ups, downs, loads, bad; bit err; logic [W-1:0] lv;
    applyStimulus(2'b00, 5'd3, 10, rsp_at, err, ups, downs, loads, bad, lv);
    bus.Req_Valid = 1'b1; bus.Req_Mode = 2'b01; bus.Req_Value = 5'd20;
    @(posedge Clk); #1;
    bus.Req_Valid = 1'b0;
    repeat (4) @(posedge Clk);
    #3;
    checks++;
    if (bus.Up !== 1'b1) begin
      errors++; $display("[TB] FAIL midseek_up: got %b want 1", bus.Up);
    end
    Rst = 1'b0;
    #1;
    checks++;
    if ({bus.Load, bus.Up, bus.Down, bus.Rsp_Valid} !== 4'b0) begin
      errors++;
      $display("[TB] FAIL midseek_reset_controls: got %b want 0000",
               {bus.Load, bus.Up, bus.Down, bus.Rsp_Valid});
    end
    @(posedge Clk); #1;
    Rst = 1'b1;
    #1;
    checks++;
    if (bus.Req_Ready !== 1'b1) begin
      errors++; $display("[TB] FAIL midseek_ready: got %b want 1", bus.Req_Ready);
    end
    for (int i = 0; i < 5; i++) begin
      @(posedge Clk); #1;
      checks++;
      if (bus.Rsp_Valid !== 1'b0 || bus.Up !== 1'b0) begin
        errors++;
        $display("[TB] FAIL midseek_no_rsp: got rsp=%b up=%b want 0 0", bus.Rsp_Valid, bus.Up);
      end
    end
    model_cnt = 0;
  endtask

  task automatic test_load;
    int rsp_at, ups, downs, loads, bad; bit err; logic [W-1:0] lv;
    applyStimulus(2'b00, 5'd17, 10, rsp_at, err, ups, downs, loads, bad, lv);
    checks++;
    if (rsp_at !== 2 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL load_rsp: got at=%0d err=%b want at=2 err=0", rsp_at, err);
    end
    checks++;
    if (loads !== 1 || lv !== 5'd17 || ups + downs !== 0 || bad !== 0) begin
      errors++;
      $display("[TB] FAIL load_ctrl: got loads=%0d in=%0d steps=%0d bad=%0d want 1 17 0 0",
               loads, lv, ups + downs, bad);
    end
    checks++;
    if (cnt !== 5'd17) begin
      errors++; $display("[TB] FAIL load_count: got %0d want 17", cnt);
    end
    model_cnt = 17;
  endtask

  task automatic test_seek;
    int rsp_at, ups, downs, loads, bad; bit err; logic [W-1:0] lv;
    applyStimulus(2'b01, 5'd9, 60, rsp_at, err, ups, downs, loads, bad, lv);
    checks++;
    if (rsp_at !== 10 || err !== 1'b0) begin
      errors++; $display("[TB] FAIL seek_rsp: got at=%0d err=%b want at=10 err=0", rsp_at, err);
    end
    checks++;
    if (downs !== 8 || ups !== 0 || loads !== 0 || bad !== 0) begin
      errors++;
      $display("[TB] FAIL seek_steps: got down=%0d up=%0d load=%0d bad=%0d want 8 0 0 0",
               downs, ups, loads, bad);
    end
    checks++;
    if (cnt !== 5'd9) begin
      errors++; $display("[TB] FAIL seek_count: got %0d want 9", cnt);
    end
    applyStimulus(2'b01, 5'd9, 60, rsp_at, err, ups, downs, loads, bad, lv);
    checks++;
    if (rsp_at !== 2 || ups + downs !== 0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL seek_equal: got at=%0d steps=%0d err=%b want at=2 steps=0 err=0",
               rsp_at, ups + downs, err);
    end
    model_cnt = 9;
  endtask

  task automatic test_ramp;
    int rsp_at, ups, downs, loads, bad; bit err; logic [W-1:0] lv;
    applyStimulus(2'b00, 5'd28, 10, rsp_at, err, ups, downs, loads, bad, lv);
    applyStimulus(2'b10, 5'd3, 60, rsp_at, err, ups, downs, loads, bad, lv);
    checks++;
    if (rsp_at !== 5 || ups !== 3 || downs !== 0 || bad !== 0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ramp_up: got at=%0d up=%0d down=%0d bad=%0d err=%b want 5 3 0 0 0",
               rsp_at, ups, downs, bad, err);
    end
    checks++;
    if (cnt !== 5'd31 || bus.High !== 1'b1) begin
      errors++; $display("[TB] FAIL ramp_up_count: got %0d want 31", cnt);
    end
    applyStimulus(2'b11, 5'd7, 60, rsp_at, err, ups, downs, loads, bad, lv);
    checks++;
    if (rsp_at !== 33 || downs !== 31 || ups !== 0 || bad !== 0 || err !== 1'b0) begin
      errors++;
      $display("[TB] FAIL ramp_down: got at=%0d down=%0d up=%0d bad=%0d err=%b want 33 31 0 0 0",
               rsp_at, downs, ups, bad, err);
    end
    checks++;
    if (cnt !== 5'd0) begin
      errors++; $display("[TB] FAIL ramp_down_count: got %0d want 0", cnt);
    end
    model_cnt = 0;
  endtask

  task automatic test_timeout;
    int rsp_at, ups, downs, loads, bad; bit err; logic [W-1:0] lv;
    applyStimulus(2'b00, 5'd4, 10, rsp_at, err, ups, downs, loads, bad, lv);
    stuck = 1'b1;
    applyStimulus(2'b01, 5'd20, 100, rsp_at, err, ups, downs, loads, bad, lv);
    stuck = 1'b0;
    checks++;
    if (ups !== TIMEOUT || downs !== 0 || bad !== 0) begin
      errors++;
      $display("[TB] FAIL timeout_steps: got up=%0d down=%0d bad=%0d want %0d 0 0",
               ups, downs, bad, TIMEOUT);
    end
    checks++;
    if (rsp_at !== TIMEOUT + 2 || err !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_rsp: got at=%0d err=%b want at=%0d err=1",
               rsp_at, err, TIMEOUT + 2);
    end
    checks++;
    if (cnt !== 5'd4) begin
      errors++; $display("[TB] FAIL timeout_count: got %0d want 4", cnt);
    end
    model_cnt = 4;
  endtask

  task automatic test_back_to_back;
    bus.Req_Valid = 1'b1; bus.Req_Mode = 2'b00; bus.Req_Value = 5'd5;
    @(posedge Clk); #1;
    bus.Req_Value = 5'd12;
    checks++;
    if (bus.Load !== 1'b1 || bus.In !== 5'd5 || bus.Req_Ready !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_first: got load=%b in=%0d ready=%b want 1 5 0",
               bus.Load, bus.In, bus.Req_Ready);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.Rsp_Valid !== 1'b1 || bus.Req_Ready !== 1'b0 || bus.Load !== 1'b0) begin
      errors++;
      $display("[TB] FAIL b2b_resp: got rsp=%b ready=%b load=%b want 1 0 0",
               bus.Rsp_Valid, bus.Req_Ready, bus.Load);
    end
    @(posedge Clk); #1;
    checks++;
    if (bus.Req_Ready !== 1'b1 || bus.Rsp_Valid !== 1'b0 || cnt !== 5'd5) begin
      errors++;
      $display("[TB] FAIL b2b_idle: got ready=%b rsp=%b cnt=%0d want 1 0 5",
               bus.Req_Ready, bus.Rsp_Valid, cnt);
    end
    @(posedge Clk); #1;
    bus.Req_Valid = 1'b0;
    checks++;
    if (bus.Load !== 1'b1 || bus.In !== 5'd12) begin
      errors++; $display("[TB] FAIL b2b_second: got load=%b in=%0d want 1 12", bus.Load, bus.In);
    end
    repeat (2) @(posedge Clk);
    #1;
    checks++;
    if (cnt !== 5'd12 || bus.Req_Ready !== 1'b1) begin
      errors++;
      $display("[TB] FAIL b2b_final: got cnt=%0d ready=%b want 12 1", cnt, bus.Req_Ready);
    end
    model_cnt = 12;
  endtask

  task automatic test_random;
    int rsp_at, ups, downs, loads, bad; bit err; logic [W-1:0] lv;
    int e_lat, e_ups, e_downs, e_loads, e_nc; bit e_err;
    int mode, value;
    for (int i = 0; i < 25; i++) begin
      mode  = int'($urandom_range(0, 3));
      value = int'($urandom_range(0, TOP));
      model_cmd(model_cnt, mode, value, e_lat, e_err, e_ups, e_downs, e_loads, e_nc);
      applyStimulus(mode[1:0], value[W-1:0], 80, rsp_at, err, ups, downs, loads, bad, lv);
      checks++;
      if (rsp_at !== e_lat || err !== e_err || ups !== e_ups || downs !== e_downs ||
          loads !== e_loads || bad !== 0 || int'(cnt) !== e_nc) begin
        errors++;
        $display("[TB] FAIL random_%0d mode=%0d val=%0d: got at=%0d err=%b up=%0d down=%0d load=%0d bad=%0d cnt=%0d want at=%0d err=%b up=%0d down=%0d load=%0d bad=0 cnt=%0d",
                 i, mode, value, rsp_at, err, ups, downs, loads, bad, cnt,
                 e_lat, e_err, e_ups, e_downs, e_loads, e_nc);
      end
      model_cnt = e_nc;
    end
  endtask

  initial begin
    test_reset;
    test_reset_mid_seek;
    test_load;
    test_seek;
    test_ramp;
    test_timeout;
    test_back_to_back;
    test_random;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1000000;
    $display("[TB] FAIL watchdog: got no completion want finish before 1000000 ns");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
